// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: parametrised N-to-1 datapath multiplexer with a single-entry registered
// output stage and valid/ready handshake. In scan mode an internal counter walks the
// inputs round-robin, advancing once per accepted transfer.
//
// Optional feature: define MUX_PARITY_EN to add output Y_Par (= ^Y, registered with Y).
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous, active-high reset
//   X          packed inputs; input i = X[i*WIDTH +: WIDTH]
//   Sel        input index used when Mode=0
//   Mode       0 = direct select, 1 = scan (internal counter)
//   In_Valid   upstream offers a selection this cycle
//   In_Ready   block can accept (combinational)
//   Y          registered selected data
//   Out_Valid  Y holds a valid result
//   Out_Ready  downstream consumes Y this cycle
//   Scan_Idx   current scan counter value
//   Sel_Err    last accepted select was out of range (status, valid with Out_Valid)
//   Y_Par      (MUX_PARITY_EN only) even parity of Y
module mux_nx1_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDTH*NUM_IN-1:0] X,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    Mode,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [WIDTH-1:0]        Y,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [SEL_W-1:0]        Scan_Idx,
  output logic                    Sel_Err
`ifdef MUX_PARITY_EN
  ,
  output logic                    Y_Par
`endif
);

  // One extra bit so NUM_IN itself is representable even when NUM_IN == 2**SEL_W.
  localparam logic [SEL_W:0]   NumInW  = (SEL_W + 1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] scan_q, scan_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] idx;
  logic             idx_oob;
  logic [WIDTH-1:0] sel_data;
  logic             accept;

  assign idx      = Mode ? scan_q : Sel;
  assign idx_oob  = ({1'b0, idx} >= NumInW);
  assign In_Ready = !valid_q || Out_Ready;
  assign accept   = In_Valid && In_Ready;

  // Compare-and-select loop: an out-of-range index matches no input and yields zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_data = X[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    y_d     = y_q;
    err_d   = err_q;
    valid_d = valid_q;
    scan_d  = scan_q;
    if (accept) begin
      y_d     = sel_data;
      err_d   = idx_oob;
      valid_d = 1'b1;
      if (Mode) begin
        scan_d = (scan_q == LastIdx) ? '0 : scan_q + 1'b1;
      end
    end else if (Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      scan_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
    end
  end

  assign Y         = y_q;
  assign Out_Valid = valid_q;
  assign Scan_Idx  = scan_q;
  assign Sel_Err   = err_q;

`ifdef MUX_PARITY_EN
  logic par_q, par_d;

  assign par_d = accept ? ^sel_data : par_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign Y_Par = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a 16-input and a 5-input instance share one stimulus stream.
// A transaction-level model predicts every output; directed sequences pin known values.
module tb_mux_nx1_pipe;

  localparam int W = 32;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [16*W-1:0] X = '0;
  logic [3:0]      Sel = '0;
  logic            Mode = 1'b0;
  logic            In_Valid = 1'b0;
  logic            Out_Ready = 1'b0;

  logic            rdy16, ov16, err16, rdy5, ov5, err5;
  logic [W-1:0]    y16, y5;
  logic [3:0]      scan16;
  logic [2:0]      scan5;
`ifdef MUX_PARITY_EN
  logic            par16, par5;
`endif

  int cnt = 0;
  int errs = 0;

  always #5 Clk = ~Clk;

  mux_nx1_pipe #(.WIDTH(W), .NUM_IN(16), .SEL_W(4)) dut16 (
    .Clk(Clk), .Reset(Reset), .X(X), .Sel(Sel), .Mode(Mode), .In_Valid(In_Valid),
    .In_Ready(rdy16), .Y(y16), .Out_Valid(ov16), .Out_Ready(Out_Ready),
    .Scan_Idx(scan16), .Sel_Err(err16)
`ifdef MUX_PARITY_EN
    , .Y_Par(par16)
`endif
  );

  mux_nx1_pipe #(.WIDTH(W), .NUM_IN(5), .SEL_W(3)) dut5 (
    .Clk(Clk), .Reset(Reset), .X(X[5*W-1:0]), .Sel(Sel[2:0]), .Mode(Mode),
    .In_Valid(In_Valid), .In_Ready(rdy5), .Y(y5), .Out_Valid(ov5), .Out_Ready(Out_Ready),
    .Scan_Idx(scan5), .Sel_Err(err5)
`ifdef MUX_PARITY_EN
    , .Y_Par(par5)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cnt++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0: 16 inputs, 1: 5 inputs) ----------------
  int unsigned  m_n[2] = '{16, 5};
  logic [W-1:0] m_y[2] = '{default: '0};
  bit           m_v[2] = '{default: 0};
  bit           m_err[2] = '{default: 0};
  int unsigned  m_scan[2] = '{default: 0};

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int d = 0; d < 2; d++) begin
        m_y[d] = '0; m_v[d] = 0; m_err[d] = 0; m_scan[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int unsigned idx;
        if (In_Valid && (!m_v[d] || Out_Ready)) begin
          idx = Mode ? m_scan[d] : ((d == 0) ? int'(Sel) : int'(Sel[2:0]));
          m_y[d]   = (idx < m_n[d]) ? X[idx*W +: W] : '0;
          m_err[d] = (idx >= m_n[d]);
          m_v[d]   = 1;
          if (Mode) m_scan[d] = (m_scan[d] + 1) % m_n[d];
        end else if (Out_Ready) begin
          m_v[d] = 0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("rdy16", 64'(rdy16), 64'(!m_v[0] || Out_Ready));
    chk("ov16", 64'(ov16), 64'(m_v[0]));
    chk("y16", 64'(y16), 64'(m_y[0]));
    chk("err16", 64'(err16), 64'(m_err[0]));
    chk("scan16", 64'(scan16), 64'(m_scan[0]));
    chk("rdy5", 64'(rdy5), 64'(!m_v[1] || Out_Ready));
    chk("ov5", 64'(ov5), 64'(m_v[1]));
    chk("y5", 64'(y5), 64'(m_y[1]));
    chk("err5", 64'(err5), 64'(m_err[1]));
    chk("scan5", 64'(scan5), 64'(m_scan[1]));
`ifdef MUX_PARITY_EN
    chk("par16", 64'(par16), 64'(^m_y[0]));
    chk("par5", 64'(par5), 64'(^m_y[1]));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_x_base();
    for (int i = 0; i < 16; i++) X[i*W +: W] = W'(32'hA0 + i);
  endtask

  initial begin
    set_x_base();
    cyc();
    cyc();
    chk("reset_y", 64'(y16), 64'h0);
    chk("reset_ov", 64'(ov16), 64'h0);
    chk("reset_scan", 64'(scan5), 64'h0);
    Reset = 1'b0;

    // Direct select, back-to-back with no bubbles.
    Mode = 1'b0; Out_Ready = 1'b1; In_Valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      Sel = 4'(s);
      cyc();
      chk("t2_y", 64'(y16), 64'(32'hA0 + s));
      chk("t2_ov", 64'(ov16), 64'h1);
    end

    // Stall holds Y while inputs change.
    Sel = 4'd3;
    cyc();
    Out_Ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Sel = 4'($urandom_range(15));
      for (int i = 0; i < 16; i++) X[i*W +: W] = $urandom;
      #1;
      chk("t3_rdy", 64'(rdy16), 64'h0);
      chk("t3_y", 64'(y16), 64'hA3);
      cyc();
    end
    set_x_base();
    Out_Ready = 1'b1; Sel = 4'd7;
    cyc();
    chk("t3_next", 64'(y16), 64'hA7);

    // Scan wrap on the 5-input instance.
    Mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t4_y", 64'(y5), 64'(32'hA0 + (k % 5)));
    end
    chk("t4_scan", 64'(scan5), 64'h2);
    Mode = 1'b0; Sel = 4'd0;
    for (int k = 0; k < 3; k++) cyc();
    chk("t4_hold", 64'(scan5), 64'h2);
    Mode = 1'b1;
    cyc();
    chk("t4_resume", 64'(y5), 64'hA2);

    // Out-of-range select.
    Mode = 1'b0; Sel = 4'd6;
    cyc();
    chk("t5_y", 64'(y5), 64'h0);
    chk("t5_err", 64'(err5), 64'h1);
    Sel = 4'd1;
    cyc();
    chk("t5_y1", 64'(y5), 64'hA1);
    chk("t5_err0", 64'(err5), 64'h0);

    // Async reset mid-stream, checked before any clock edge.
    Mode = 1'b1;
    cyc();
    Out_Ready = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("t1_y", 64'(y16), 64'h0);
    chk("t1_ov", 64'(ov16), 64'h0);
    chk("t1_scan16", 64'(scan16), 64'h0);
    chk("t1_scan5", 64'(scan5), 64'h0);
    cyc();
    Reset = 1'b0;

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 16; i++) X[i*W +: W] = $urandom;
      Sel = 4'($urandom_range(15));
      Mode = 1'($urandom_range(1));
      In_Valid = ($urandom_range(3) != 0);
      Out_Ready = ($urandom_range(3) != 0);
      cyc();
    end

`ifdef MUX_PARITY_EN
    Mode = 1'b0; Out_Ready = 1'b1; In_Valid = 1'b1; Sel = 4'd0;
    X[W-1:0] = 32'h0000_0007;
    cyc();
    chk("t6_par1", 64'(par16), 64'h1);
    X[W-1:0] = 32'h0000_0003;
    cyc();
    chk("t6_par0", 64'(par16), 64'h0);
`endif

    In_Valid = 1'b0;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end

endmodule
